// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB/BHT with 2-bit saturating direction
// counters, plus resolved-branch and mispredict statistics.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   pc_if              IF-stage PC to predict
//   jump_guess_if      predicted taken (hit and counter MSB set)
//   pc_guess_if        predicted target on a hit, else pc_if+4
//   ex_valid           EX stage holds a resolved branch/jump
//   pc_ex, jump_ex,    PC, actual outcome and actual target of that branch
//   target_ex
//   jump_guess_ex      prediction that travelled with the EX branch
//   bp_clear           invalidate every entry at the next edge
//   mispredict_ex      direction mispredict in EX (combinational)
//   br_cnt, miss_cnt   saturating resolved-branch / mispredict counters
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_if,
  output logic        jump_guess_if,
  output logic [31:0] pc_guess_if,
  input  logic        ex_valid,
  input  logic [31:0] pc_ex,
  input  logic        jump_ex,
  input  logic [31:0] target_ex,
  input  logic        jump_guess_ex,
  input  logic        bp_clear,
  output logic        mispredict_ex,
  output logic [15:0] br_cnt,
  output logic [15:0] miss_cnt
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0]   idx_if;
  logic [TAG_W-1:0]   tag_if;
  logic               hit_if;
  logic [IDX_W-1:0]   idx_ex;
  logic [TAG_W-1:0]   tag_ex;
  logic               hit_ex;
  logic               unused_pc_lsb;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken && c != 2'b11)
      r = c + 2'b01;
    else if (!taken && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // instruction addresses are word aligned; the low two bits carry no information
  assign unused_pc_lsb = ^{pc_if[1:0], pc_ex[1:0]};

  // IF lookup: combinational from registered table state, no bypass of same-cycle update
  assign idx_if        = pc_if[IDX_W+1:2];
  assign tag_if        = pc_if[31:IDX_W+2];
  assign hit_if        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign jump_guess_if = hit_if && ctr_q[idx_if][1];
  assign pc_guess_if   = hit_if ? target_q[idx_if] : pc_if + 32'd4;

  // EX resolve
  assign idx_ex        = pc_ex[IDX_W+1:2];
  assign tag_ex        = pc_ex[31:IDX_W+2];
  assign hit_ex        = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
  assign mispredict_ex = ex_valid && (jump_guess_ex ^ jump_ex);

  // table update at the clock edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bp_clear) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
    end else if (ex_valid) begin
      if (hit_ex) begin
        ctr_q[idx_ex] <= ctr_next(ctr_q[idx_ex], jump_ex);
        if (jump_ex)
          target_q[idx_ex] <= target_ex;
      end else if (jump_ex) begin
        valid_q[idx_ex]  <= 1'b1;
        tag_q[idx_ex]    <= tag_ex;
        target_q[idx_ex] <= target_ex;
        ctr_q[idx_ex]    <= 2'b10;
      end
    end
  end

  // statistics counters, unaffected by bp_clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (ex_valid)
        br_cnt <= sat_inc(br_cnt);
      if (mispredict_ex)
        miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rstn;
  logic [31:0] pc_if;
  logic        jump_guess_if;
  logic [31:0] pc_guess_if;
  logic        ex_valid;
  logic [31:0] pc_ex;
  logic        jump_ex;
  logic [31:0] target_ex;
  logic        jump_guess_ex;
  logic        bp_clear;
  logic        mispredict_ex;
  logic [15:0] br_cnt;
  logic [15:0] miss_cnt;

  int n_pass = 0;
  int n_total = 0;

  branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .pc_if         (pc_if),
    .jump_guess_if (jump_guess_if),
    .pc_guess_if   (pc_guess_if),
    .ex_valid      (ex_valid),
    .pc_ex         (pc_ex),
    .jump_ex       (jump_ex),
    .target_ex     (target_ex),
    .jump_guess_ex (jump_guess_ex),
    .bp_clear      (bp_clear),
    .mispredict_ex (mispredict_ex),
    .br_cnt        (br_cnt),
    .miss_cnt      (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Check the prediction for a given IF PC (combinational, no edge needed).
  task automatic look(input string tag, input logic [31:0] pc, input logic jg, input logic [31:0] pg);
    pc_if = pc;
    #1;
    chk({tag, "_jg"}, {31'd0, jump_guess_if}, {31'd0, jg});
    chk({tag, "_pg"}, pc_guess_if, pg);
  endtask

  // Present one resolved branch for one clock edge; checks mispredict_ex before the edge.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic j,
                         input logic [31:0] t, input logic g, input logic exp_mp);
    ex_valid = 1'b1; pc_ex = pc; jump_ex = j; target_ex = t; jump_guess_ex = g;
    #1;
    chk({tag, "_mp"}, {31'd0, mispredict_ex}, {31'd0, exp_mp});
    @(posedge clk); #1;
    ex_valid = 1'b0; jump_ex = 1'b0; jump_guess_ex = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; pc_if = 32'h100; ex_valid = 1'b0; pc_ex = '0; jump_ex = 1'b0;
    target_ex = '0; jump_guess_ex = 1'b0; bp_clear = 1'b0;
    #3;
    chk("rst_jg", {31'd0, jump_guess_if}, 32'd0);
    chk("rst_pg", pc_guess_if, 32'h104);
    chk("rst_br", {16'd0, br_cnt}, 32'd0);
    chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
    #20 rstn = 1'b1;
    @(posedge clk); #1;

    look("idle", 32'h100, 1'b0, 32'h104);
    chk("idle_br", {16'd0, br_cnt}, 32'd0);

    // first taken resolve allocates; same-cycle lookup sees the old state
    ex_valid = 1'b1; pc_ex = 32'h100; jump_ex = 1'b1; target_ex = 32'h200; jump_guess_ex = 1'b0;
    #1;
    chk("alloc_mp", {31'd0, mispredict_ex}, 32'd1);
    look("nobypass", 32'h100, 1'b0, 32'h104);
    @(posedge clk); #1;
    ex_valid = 1'b0; jump_ex = 1'b0;
    #1;
    chk("alloc_mp_idle", {31'd0, mispredict_ex}, 32'd0);
    look("alloc", 32'h100, 1'b1, 32'h200);
    chk("alloc_br", {16'd0, br_cnt}, 32'd1);
    chk("alloc_miss", {16'd0, miss_cnt}, 32'd1);

    // counter walk: 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2
    resolve("nt1", 32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
    look("nt1", 32'h100, 1'b0, 32'h200);
    resolve("nt2", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    look("nt2", 32'h100, 1'b0, 32'h200);
    resolve("nt3", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    resolve("t1", 32'h100, 1'b1, 32'h200, 1'b0, 1'b1);
    look("t1", 32'h100, 1'b0, 32'h200);
    resolve("t2", 32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    look("t2", 32'h100, 1'b1, 32'h200);
    resolve("t3", 32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    resolve("t4", 32'h100, 1'b1, 32'h204, 1'b1, 1'b0);
    look("t4", 32'h100, 1'b1, 32'h204);
    resolve("nt4", 32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
    look("sat3", 32'h100, 1'b1, 32'h204);
    chk("walk_br", {16'd0, br_cnt}, 32'd9);
    chk("walk_miss", {16'd0, miss_cnt}, 32'd4);

    // not-taken miss leaves the table alone
    resolve("ntmiss", 32'h180, 1'b0, 32'h0, 1'b0, 1'b0);
    look("ntmiss_180", 32'h180, 1'b0, 32'h184);
    look("ntmiss_100", 32'h100, 1'b1, 32'h204);

    // ex_valid low: no update and no count
    ex_valid = 1'b0; pc_ex = 32'h140; jump_ex = 1'b1; target_ex = 32'h280; jump_guess_ex = 1'b0;
    #1;
    chk("novalid_mp", {31'd0, mispredict_ex}, 32'd0);
    @(posedge clk); #1;
    jump_ex = 1'b0;
    look("novalid", 32'h140, 1'b0, 32'h144);
    chk("novalid_br", {16'd0, br_cnt}, 32'd10);

    // alias: 0x140 shares index 0 with 0x100 and replaces it
    resolve("alias", 32'h140, 1'b1, 32'h280, 1'b0, 1'b1);
    look("alias_100", 32'h100, 1'b0, 32'h104);
    look("alias_140", 32'h140, 1'b1, 32'h280);
    chk("alias_miss", {16'd0, miss_cnt}, 32'd5);

    // bp_clear beats a same-cycle taken update
    bp_clear = 1'b1;
    resolve("clr", 32'h300, 1'b1, 32'h380, 1'b0, 1'b1);
    bp_clear = 1'b0;
    look("clr_100", 32'h100, 1'b0, 32'h104);
    look("clr_140", 32'h140, 1'b0, 32'h144);
    look("clr_300", 32'h300, 1'b0, 32'h304);
    chk("clr_br", {16'd0, br_cnt}, 32'd12);
    chk("clr_miss", {16'd0, miss_cnt}, 32'd6);

    // flood with mispredicts to saturate both counters
    pc_if = 32'h100;
    ex_valid = 1'b1; pc_ex = 32'h100; jump_ex = 1'b1; target_ex = 32'h200; jump_guess_ex = 1'b0;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    chk("sat_miss", {16'd0, miss_cnt}, 32'h0000FFFF);
    chk("sat_br", {16'd0, br_cnt}, 32'h0000FFFF);
    chk("sat_jg", {31'd0, jump_guess_if}, 32'd1);

    // asynchronous reset mid-cycle, while an update is being presented
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_jg", {31'd0, jump_guess_if}, 32'd0);
    chk("arst_pg", pc_guess_if, 32'h104);
    chk("arst_br", {16'd0, br_cnt}, 32'd0);
    chk("arst_miss", {16'd0, miss_cnt}, 32'd0);
    ex_valid = 1'b0; jump_ex = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    #1;
    look("post_rst", 32'h100, 1'b0, 32'h104);
    resolve("post_rst_upd", 32'h100, 1'b1, 32'h220, 1'b0, 1'b1);
    look("post_rst_upd", 32'h100, 1'b1, 32'h220);
    chk("post_rst_br", {16'd0, br_cnt}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, meaning the number of direct-mapped BTB/BHT entries (a power of two, 4..64).
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning log2(ENTRIES).
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-low (clk, rstn).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 pc_if  input  32  IF-stage PC to predict.
REQ-007 jump_guess_if  output  1  IF prediction: taken.
REQ-008 pc_guess_if  output  32  predicted target; valid when jump_guess_if=1.
REQ-009 ex_valid  input  1  EX stage holds a resolved branch/jump this cycle.
REQ-010 pc_ex  input  32  PC of the EX-stage branch.
REQ-011 jump_ex  input  1  actual outcome: taken.
REQ-012 target_ex  input  32  actual target of the EX-stage branch.
REQ-013 jump_guess_ex  input  1  prediction that travelled with the EX-stage branch.
REQ-014 bp_clear  input  1  synchronous invalidate of all entries (e.g. fence.i).
REQ-015 mispredict_ex  output  1  direction mispredict in EX.
REQ-016 br_cnt  output  16  resolved-branch count.
REQ-017 miss_cnt  output  16  mispredict count.

Function
REQ-018 Each entry SHALL hold valid(1), tag(32-IDX_W-2), target(32) and a 2-bit saturating counter ctr.
REQ-019 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[31:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-020 Lookup SHALL be combinational from registered table state: hit = valid & tag match for pc_if.
REQ-021 jump_guess_if SHALL equal hit & ctr[1]; pc_guess_if SHALL equal the entry target when hit, else pc_if+4.
REQ-022 mispredict_ex SHALL equal ex_valid & (jump_guess_ex ^ jump_ex), combinationally.
REQ-023 On a rising edge with ex_valid=1 and bp_clear=0, if pc_ex hits: ctr SHALL increment if jump_ex=1 (saturating at 3), else decrement (saturating at 0).
REQ-024 Same hit case with jump_ex=1: target SHALL be overwritten with target_ex.
REQ-025 On ex_valid=1, a miss and jump_ex=1: entry SHALL be allocated/replaced: valid=1, tag from pc_ex, target=target_ex, ctr=2'b10.
REQ-026 On ex_valid=1, a miss and jump_ex=0: the table SHALL be unchanged.
REQ-027 ex_valid=0: the table SHALL be unchanged.
REQ-028 A same-index lookup and update in the same cycle SHALL NOT bypass: the lookup returns the pre-edge state; the update is visible from the next cycle.
REQ-029 bp_clear=1 SHALL, at the edge, clear every valid bit and set every ctr to 2'b01; it SHALL take priority over any same-cycle update; targets and tags need not change.
REQ-030 br_cnt SHALL increment on each edge with ex_valid=1; miss_cnt SHALL increment on each edge with mispredict_ex=1; both SHALL saturate at 16'hFFFF; bp_clear SHALL NOT affect them.
REQ-031 Total latency: prediction 0 cycles; update visible 1 cycle after the edge.

Reset
REQ-032 rstn=0 SHALL immediately, regardless of clk, clear all valid bits, set all ctr=2'b01, targets/tags=0, br_cnt=miss_cnt=0.
REQ-033 During reset jump_guess_if SHALL be 0 and pc_guess_if SHALL be pc_if+4.
REQ-034 Reset asserted mid-update SHALL discard that update; the first update SHALL occur on the first rising edge with rstn=1.

Verification
REQ-035 After reset, pc_if=0x100 -> jump_guess_if=0, pc_guess_if=0x104; br_cnt=miss_cnt=0.
REQ-036 EX pc_ex=0x100, jump_ex=1, target_ex=0x200, jump_guess_ex=0 -> mispredict_ex=1 that cycle; next cycle pc_if=0x100 gives jump_guess_if=1, pc_guess_if=0x200, miss_cnt=1, br_cnt=1.
REQ-037 Same entry, then two not-taken resolves -> ctr 2->1->0; jump_guess_if=0 after the first; a third not-taken keeps ctr=0; four taken resolves saturate at 3.
REQ-038 Alias test: allocate 0x100 taken, then resolve 0x140 taken (same index for ENTRIES=16) -> 0x100 misses (jump_guess_if=0), 0x140 predicts its target_ex.
REQ-039 bp_clear=1 in the same cycle as a taken ex_valid update for 0x300 -> next cycle both 0x100 and 0x300 predict not-taken; br_cnt still increments.
REQ-040 Drive 65536+ mispredicts -> miss_cnt holds 16'hFFFF; assert rstn low mid-cycle -> all outputs reset without a clock edge.
